layer_color_mapper: RTL and testbench

LAYER_COLOR_MAPPER -- requirements
Module: layer_color_mapper

---
 rtl/color_pkg.sv | 20 ++
 rtl/palette_regs.sv | 36 +++
 rtl/layer_color_mapper.sv | 121 ++++++++++++
 tb/tb_layer_color_mapper.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared colour types, default parameters and index-width helper
package color_pkg;

    localparam int DEF_COLOR_W      = 4;
    localparam int DEF_NUM_LAYERS   = 3;
    localparam int DEF_PAL_DEPTH    = 16;
    localparam int DEF_BLINK_FRAMES = 30;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    // Palette index width; a one-entry palette still needs a 1-bit address.
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/palette_regs.sv
// rtl/palette_regs.sv - register-file palette with a registered, blanking read port
module palette_regs
    import color_pkg::*;
#(
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int PAL_DEPTH = DEF_PAL_DEPTH,
    parameter int IDX_W     = idx_w(DEF_PAL_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [3*COLOR_W-1:0] wdata,
    input  logic                 rd_valid,
    input  logic [IDX_W-1:0]     raddr,
    output logic [3*COLOR_W-1:0] rdata
);

    logic [3*COLOR_W-1:0] pal [PAL_DEPTH];

    // The read samples the pre-edge contents, so a same-edge write is seen one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAL_DEPTH; i++) begin
                pal[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                pal[waddr] <= wdata;
            end
            rdata <= rd_valid ? pal[raddr] : '0;
        end
    end

endmodule

// File: rtl/layer_color_mapper.sv
// rtl/layer_color_mapper.sv - priority layer select, blink and palette lookup, 2-cycle pixel pipeline
module layer_color_mapper
    import color_pkg::*;
#(
    parameter int  COLOR_W      = DEF_COLOR_W,
    parameter int  NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int  PAL_DEPTH    = DEF_PAL_DEPTH,
    parameter int  BLINK_FRAMES = DEF_BLINK_FRAMES,
    localparam int IDX_W        = idx_w(PAL_DEPTH)
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_start,
    input  logic                        pix_valid,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]       blink_en,
    input  logic                        inverse,
    input  logic                        pal_we,
    input  logic [IDX_W-1:0]            pal_waddr,
    input  logic [3*COLOR_W-1:0]        pal_wdata,
    output logic [COLOR_W-1:0]          VGA_R,
    output logic [COLOR_W-1:0]          VGA_G,
    output logic [COLOR_W-1:0]          VGA_B,
    output logic                        pix_valid_out,
    output logic [9:0]                  DrawX_out,
    output logic [9:0]                  DrawY_out
);

    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0]      blink_cnt;
    logic                  blink_phase;
    logic [NUM_LAYERS-1:0] active;
    logic                  any_hit;
    logic                  is_fore;
    logic [IDX_W-1:0]      winner_idx;
    logic [IDX_W-1:0]      sel_idx;

    logic                  valid_s1;
    logic [IDX_W-1:0]      idx_s1;
    logic [9:0]            x_s1;
    logic [9:0]            y_s1;
    logic [3*COLOR_W-1:0]  rgb_s2;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Walking from the top index down lets the lowest active layer overwrite last and win.
    always_comb begin
        active     = layer_hit & ~(blink_en & {NUM_LAYERS{blink_phase}});
        any_hit    = |active;
        is_fore    = any_hit ^ inverse;
        winner_idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (active[i]) begin
                winner_idx = layer_idx[i*IDX_W +: IDX_W];
            end
        end
        if (is_fore && any_hit) begin
            sel_idx = winner_idx;
        end else if (is_fore) begin
            sel_idx = IDX_W'(PAL_DEPTH - 1);
        end else begin
            sel_idx = '0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_s1      <= 1'b0;
            idx_s1        <= '0;
            x_s1          <= '0;
            y_s1          <= '0;
            pix_valid_out <= 1'b0;
            DrawX_out     <= '0;
            DrawY_out     <= '0;
        end else begin
            valid_s1      <= pix_valid;
            idx_s1        <= sel_idx;
            x_s1          <= DrawX;
            y_s1          <= DrawY;
            pix_valid_out <= valid_s1;
            DrawX_out     <= x_s1;
            DrawY_out     <= y_s1;
        end
    end

    palette_regs #(
        .COLOR_W   (COLOR_W),
        .PAL_DEPTH (PAL_DEPTH),
        .IDX_W     (IDX_W)
    ) u_palette (
        .clk      (Clk),
        .rst      (Reset),
        .we       (pal_we),
        .waddr    (pal_waddr),
        .wdata    (pal_wdata),
        .rd_valid (valid_s1),
        .raddr    (idx_s1),
        .rdata    (rgb_s2)
    );

    assign VGA_R = rgb_s2[3*COLOR_W-1 -: COLOR_W];
    assign VGA_G = rgb_s2[2*COLOR_W-1 -: COLOR_W];
    assign VGA_B = rgb_s2[COLOR_W-1:0];

endmodule

// File: tb/tb_layer_color_mapper.sv
// tb/tb_layer_color_mapper.sv - scoreboard bench for layer_color_mapper with directed vectors
module tb_layer_color_mapper;
    import color_pkg::*;

    localparam int CW = 4;
    localparam int NL = 3;
    localparam int PD = 16;
    localparam int IW = 4;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           frame_start = 1'b0;
    logic           pix_valid = 1'b0;
    logic [9:0]     DrawX = '0;
    logic [9:0]     DrawY = '0;
    logic [NL-1:0]  layer_hit = '0;
    logic [NL*IW-1:0] layer_idx = '0;
    logic [NL-1:0]  blink_en = '0;
    logic           inverse = 1'b0;
    logic           pal_we = 1'b0;
    logic [IW-1:0]  pal_waddr = '0;
    logic [3*CW-1:0] pal_wdata = '0;
    logic [CW-1:0]  VGA_R, VGA_G, VGA_B;
    logic           pix_valid_out;
    logic [9:0]     DrawX_out, DrawY_out;

    layer_color_mapper #(
        .COLOR_W(CW), .NUM_LAYERS(NL), .PAL_DEPTH(PD), .BLINK_FRAMES(2)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .layer_hit(layer_hit), .layer_idx(layer_idx),
        .blink_en(blink_en), .inverse(inverse), .pal_we(pal_we), .pal_waddr(pal_waddr),
        .pal_wdata(pal_wdata), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .pix_valid_out(pix_valid_out), .DrawX_out(DrawX_out), .DrawY_out(DrawY_out)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        rgb_t       rgb;
        logic [9:0] x;
        logic [9:0] y;
        int         due;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int pix_n    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pal_write(input logic [IW-1:0] addr, input logic [3*CW-1:0] data);
        pal_we    = 1'b1;
        pal_waddr = addr;
        pal_wdata = data;
        step();
        pal_we    = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send_pix(input logic [NL-1:0] hit, input logic [NL*IW-1:0] idx,
                            input logic [NL-1:0] blink, input logic inv,
                            input logic [3*CW-1:0] rgb, input bit push = 1'b1);
        exp_t e;
        pix_valid = 1'b1;
        layer_hit = hit;
        layer_idx = idx;
        blink_en  = blink;
        inverse   = inv;
        DrawX     = 10'(pix_n * 7);
        DrawY     = 10'(pix_n + 100);
        if (push) begin
            e.rgb = rgb_t'(rgb);
            e.x   = DrawX;
            e.y   = DrawY;
            e.due = cyc + 2;
            sb.push_back(e);
        end
        pix_n++;
        step();
        pix_valid = 1'b0;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (pix_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected pixel: got rgb %0h with empty scoreboard", {VGA_R, VGA_G, VGA_B});
            end else begin
                e = sb.pop_front();
                check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
                check("drawx_out", 32'(DrawX_out), 32'(e.x));
                check("drawy_out", 32'(DrawY_out), 32'(e.y));
                check("latency", cyc, e.due);
            end
        end else begin
            check("blanking", 32'({pix_valid_out, VGA_R, VGA_G, VGA_B}), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset pix_valid_out", 32'(pix_valid_out), 32'd0);
        check("reset vga", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        check("reset drawxy_out", 32'({DrawX_out, DrawY_out}), 32'd0);
        @(posedge Clk);
        #1 Reset = 1'b0;

        pal_write(4'd3, 12'hF00);
        pal_write(4'd0, 12'h000);
        pal_write(4'd5, 12'h0F0);
        pal_write(4'd7, 12'h00F);
        pal_write(4'd15, 12'hFFF);

        send_pix(3'b001, 12'h003, 3'b000, 1'b0, 12'hF00);
        send_pix(3'b110, 12'h750, 3'b000, 1'b0, 12'h0F0);
        send_pix(3'b100, 12'h700, 3'b000, 1'b0, 12'h00F);
        send_pix(3'b000, 12'h753, 3'b000, 1'b1, 12'hFFF);
        send_pix(3'b001, 12'h753, 3'b000, 1'b1, 12'h000);
        send_pix(3'b111, 12'h753, 3'b000, 1'b0, 12'hF00);

        pal_write(4'd0, 12'h123);
        send_pix(3'b000, 12'h753, 3'b000, 1'b0, 12'h123);
        send_pix(3'b001, 12'h753, 3'b000, 1'b1, 12'h123);

        send_pix(3'b001, 12'h003, 3'b000, 1'b0, 12'hF00);
        pal_we    = 1'b1;
        pal_waddr = 4'd3;
        pal_wdata = 12'h0AB;
        send_pix(3'b001, 12'h003, 3'b000, 1'b0, 12'h0AB);
        pal_we    = 1'b0;

        pulse_frame();
        send_pix(3'b001, 12'h003, 3'b001, 1'b0, 12'h0AB);
        frame_start = 1'b1;
        send_pix(3'b001, 12'h003, 3'b001, 1'b0, 12'h0AB);
        frame_start = 1'b0;
        send_pix(3'b001, 12'h003, 3'b001, 1'b0, 12'h123);
        send_pix(3'b011, 12'h053, 3'b001, 1'b0, 12'h0F0);
        send_pix(3'b001, 12'h003, 3'b001, 1'b1, 12'hFFF);
        pulse_frame();
        send_pix(3'b001, 12'h003, 3'b001, 1'b0, 12'h123);
        pulse_frame();
        send_pix(3'b001, 12'h003, 3'b001, 1'b0, 12'h0AB);

        repeat (3) step();
        send_pix(3'b001, 12'h003, 3'b000, 1'b0, 12'h000, 1'b0);
        send_pix(3'b001, 12'h003, 3'b000, 1'b0, 12'h000, 1'b0);
        Reset = 1'b1;
        #1;
        check("flush pix_valid_out", 32'(pix_valid_out), 32'd0);
        check("flush vga", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        pal_we      = 1'b1;
        pal_waddr   = 4'd3;
        pal_wdata   = 12'hFFF;
        frame_start = 1'b1;
        step();
        step();
        pal_we      = 1'b0;
        frame_start = 1'b0;
        Reset       = 1'b0;

        send_pix(3'b001, 12'h003, 3'b000, 1'b0, 12'h000);
        send_pix(3'b000, 12'h003, 3'b000, 1'b1, 12'h000);

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        step();
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
